// File: rtl/controle_cache_2vias_if.sv
// Bus bundle for the 2-way cache controller.
// CPU side: cpu_req/cpu_write/cpu_addr/cpu_wdata in, cpu_ready/cpu_done/
//           cpu_hit/cpu_err/cpu_rdata out.
// Memory side: mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in.
// Statistics: hit_count/miss_count out.
// slave  = the cache controller, master = the CPU/memory environment.
interface controle_cache_2vias_if;
  logic       cpu_req;
  logic       cpu_write;
  logic [4:0] cpu_addr;
  logic [4:0] cpu_wdata;
  logic       cpu_ready;
  logic       cpu_done;
  logic       cpu_hit;
  logic       cpu_err;
  logic [4:0] cpu_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [4:0] mem_wdata;
  logic       mem_ack;
  logic [4:0] mem_rdata;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_hit, cpu_err, cpu_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_hit, cpu_err, cpu_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/controle_cache_2vias.sv
// 2-set x 2-way write-back cache controller with LRU replacement and a
// memory acknowledge timeout.
// Ports: clock, resetn (async, active-low), bus (controle_cache_2vias_if.slave).
// Array entries are addressed as {set, way}.
//
// state     | meaning
// IDLE      | ready, waiting for cpu_req
// LOOKUP    | tag compare, hit update or victim choice
// WRITEBACK | dirty victim being written to memory
// FILL      | requested block being read from memory
// DONE      | completion pulse (hit/miss)
// ERROR     | completion pulse with memory timeout
module controle_cache_2vias #(
  parameter int ACK_TIMEOUT = 15
) (
  input logic clock,
  input logic resetn,
  controle_cache_2vias_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, DONE, ERROR} state_t;
  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  state_t     state_q, state_d;
  logic [4:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       write_q, write_d, victim_q, victim_d;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] valid_q, valid_d, lru_q, lru_d, dirty_q, dirty_d;
  logic [3:0] tag_q [4];
  logic [3:0] tag_d [4];
  logic [4:0] data_q [4];
  logic [4:0] data_d [4];

  logic       cpu_ready_q, cpu_ready_d, cpu_done_q, cpu_done_d;
  logic       cpu_hit_q, cpu_hit_d, cpu_err_q, cpu_err_d;
  logic [4:0] cpu_rdata_q, cpu_rdata_d;
  logic       mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [4:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic       set_idx, hit0, hit1, hit_way, vic_way, ack_taken, done_hit;
  logic       do_install, ins_way, upd_lru, upd_way;
  logic [4:0] ins_data;

  assign set_idx   = addr_q[0];
  assign hit0      = valid_q[{set_idx, 1'b0}] && (tag_q[{set_idx, 1'b0}] == addr_q[4:1]);
  assign hit1      = valid_q[{set_idx, 1'b1}] && (tag_q[{set_idx, 1'b1}] == addr_q[4:1]);
  assign hit_way   = !hit0;
  // an ack only counts while our request is visible on the bus
  assign ack_taken = mem_req_q && bus.mem_ack;

  always_comb begin
    vic_way = 1'b0;
    if (!valid_q[{set_idx, 1'b0}])      vic_way = 1'b0;
    else if (!valid_q[{set_idx, 1'b1}]) vic_way = 1'b1;
    else if (!lru_q[{set_idx, 1'b0}])   vic_way = 1'b0;
    else if (!lru_q[{set_idx, 1'b1}])   vic_way = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    tmo_d      = tmo_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    cpu_rdata_d = '0;
    done_hit   = 1'b0;
    do_install = 1'b0;
    ins_way    = 1'b0;
    ins_data   = '0;
    upd_lru    = 1'b0;
    upd_way    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          write_d = bus.cpu_write;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          done_hit = 1'b1;
          upd_lru  = 1'b1;
          upd_way  = hit_way;
          if (write_q) begin
            data_d[{set_idx, hit_way}]  = wdata_q;
            dirty_d[{set_idx, hit_way}] = 1'b1;
          end else begin
            cpu_rdata_d = data_q[{set_idx, hit_way}];
          end
          state_d = DONE;
        end else begin
          victim_d = vic_way;
          if (valid_q[{set_idx, vic_way}] && dirty_q[{set_idx, vic_way}]) begin
            state_d = WRITEBACK;
            tmo_d   = TMO;
          end else if (!write_q) begin
            state_d = FILL;
            tmo_d   = TMO;
          end else begin
            do_install = 1'b1;
            ins_way    = vic_way;
            ins_data   = wdata_q;
            state_d    = DONE;
          end
        end
      end
      WRITEBACK: begin
        if (ack_taken) begin
          dirty_d[{set_idx, victim_q}] = 1'b0;
          if (write_q) begin
            do_install = 1'b1;
            ins_way    = victim_q;
            ins_data   = wdata_q;
            state_d    = DONE;
          end else begin
            state_d = FILL;
            tmo_d   = TMO;
          end
        end else if (mem_req_q) begin
          if (tmo_q <= 8'd1) state_d = ERROR;
          else               tmo_d   = tmo_q - 8'd1;
        end
      end
      FILL: begin
        if (ack_taken) begin
          do_install  = 1'b1;
          ins_way     = victim_q;
          ins_data    = bus.mem_rdata;
          cpu_rdata_d = bus.mem_rdata;
          state_d     = DONE;
        end else if (mem_req_q) begin
          if (tmo_q <= 8'd1) state_d = ERROR;
          else               tmo_d   = tmo_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // fills install clean, write misses install dirty
    if (do_install) begin
      valid_d[{set_idx, ins_way}] = 1'b1;
      dirty_d[{set_idx, ins_way}] = write_q;
      tag_d[{set_idx, ins_way}]   = addr_q[4:1];
      data_d[{set_idx, ins_way}]  = ins_data;
      upd_lru = 1'b1;
      upd_way = ins_way;
    end
    if (upd_lru) begin
      lru_d[{set_idx, upd_way}]  = 1'b1;
      lru_d[{set_idx, !upd_way}] = 1'b0;
    end
  end

  always_comb begin
    cpu_ready_d = (state_d == IDLE);
    cpu_done_d  = (state_d == DONE) || (state_d == ERROR);
    cpu_err_d   = (state_d == ERROR);
    cpu_hit_d   = done_hit;
    // the cycle after an accepted ack always shows mem_req low, even when
    // a write-back is followed straight by a fill
    mem_req_d   = ((state_d == WRITEBACK) || (state_d == FILL)) && !ack_taken;
    mem_we_d    = (state_d == WRITEBACK);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == WRITEBACK) begin
      mem_addr_d  = {tag_q[{set_idx, victim_d}], set_idx};
      mem_wdata_d = data_q[{set_idx, victim_d}];
    end else if (state_d == FILL) begin
      mem_addr_d  = addr_q;
    end
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_d == DONE) begin
      if (done_hit) begin
        if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
      end else begin
        if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      victim_q     <= 1'b0;
      tmo_q        <= '0;
      valid_q      <= '0;
      lru_q        <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      cpu_ready_q  <= 1'b1;
      cpu_done_q   <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      tmo_q        <= tmo_d;
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_done_q   <= cpu_done_d;
      cpu_hit_q    <= cpu_hit_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.cpu_hit    = cpu_hit_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule
